// File: rtl/handshake_pe2wb_if.sv
// PE-result / writeback bundle for handshake_pe2wb: the PE-side push channel,
// the registered backpressure back to the scheduler, and the writeback drain channel.
interface handshake_pe2wb_if #(
  parameter int PE_COL_NUM = 32,
  parameter int PSUM_WIDTH = 24
);
  // Valid/ready: a wb beat transfers on a clock edge where wb_vld_o && wb_rdy_i.
  // wb_vld_o never depends on wb_rdy_i, and wb_* hold steady while valid && !ready.
  // The PE side has no per-beat ready: it may push whenever pe2sch_rdy was seen high,
  // and up to SLACK more beats may still land after pe2sch_rdy falls.
  logic                             pe_vld_i;
  logic                             pe_row_start_i;
  logic                             pe_row_done_i;
  logic [PE_COL_NUM-1:0]            pe_col_vld_i;
  logic [PE_COL_NUM*PSUM_WIDTH-1:0] pe_psum_i;
  logic                             pe2sch_rdy;
  logic                             wb_vld_o;
  logic                             wb_rdy_i;
  logic                             wb_row_start_o;
  logic                             wb_row_done_o;
  logic [PE_COL_NUM-1:0]            wb_col_vld_o;
  logic [PE_COL_NUM*PSUM_WIDTH-1:0] wb_psum_o;

  modport slave (
    input  pe_vld_i, pe_row_start_i, pe_row_done_i, pe_col_vld_i, pe_psum_i, wb_rdy_i,
    output pe2sch_rdy, wb_vld_o, wb_row_start_o, wb_row_done_o, wb_col_vld_o, wb_psum_o
  );

  modport master (
    output pe_vld_i, pe_row_start_i, pe_row_done_i, pe_col_vld_i, pe_psum_i, wb_rdy_i,
    input  pe2sch_rdy, wb_vld_o, wb_row_start_o, wb_row_done_o, wb_col_vld_o, wb_psum_o
  );
endinterface

// File: rtl/handshake_pe2wb.sv
// Receive-side FIFO between PE array outputs and writeback, with registered slack-based
// backpressure. Optional drained-row counter enabled by HANDSHAKE_PE2WB_ROW_CNT_EN.
module handshake_pe2wb #(
  parameter int PE_COL_NUM = 32,
  parameter int PSUM_WIDTH = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int SLACK      = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  handshake_pe2wb_if.slave              bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic                          ovf_err_o,
  output logic [15:0]                   row_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = PE_COL_NUM * PSUM_WIDTH;
  localparam int EW = 2 + PE_COL_NUM + DW;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] SLACK_C = CW'(SLACK);

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_rdy;
  logic          r_ovf;

  logic [CW-1:0] w_cnt_nxt;
  logic          w_full;
  logic          w_vld;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_rdy_nxt;
  logic [EW-1:0] w_wr_entry;
  logic [EW-1:0] w_head;

  assign w_full = (r_cnt == DEPTH_C);
  assign w_vld  = (r_cnt != '0);
  assign w_pop  = w_vld & bus.wb_rdy_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts a beat.
  assign w_push = bus.pe_vld_i & (~w_full | w_pop);
  assign w_drop = bus.pe_vld_i & w_full & ~w_pop;

  assign w_wr_entry = {bus.pe_row_start_i, bus.pe_row_done_i, bus.pe_col_vld_i, bus.pe_psum_i};

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CW'(1);
      2'b01:   w_cnt_nxt = r_cnt - CW'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  assign w_rdy_nxt = ((DEPTH_C - w_cnt_nxt) > SLACK_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_rdy    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt <= w_cnt_nxt;
      r_rdy <= w_rdy_nxt;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset: an empty FIFO masks the head to zero below.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  assign w_head = r_mem[r_rd_ptr] & {EW{w_vld}};

  assign bus.wb_vld_o = w_vld;
  assign {bus.wb_row_start_o, bus.wb_row_done_o, bus.wb_col_vld_o, bus.wb_psum_o} = w_head;
  assign bus.pe2sch_rdy = r_rdy;
  assign fifo_cnt_o     = r_cnt;
  assign ovf_err_o      = r_ovf;

`ifdef HANDSHAKE_PE2WB_ROW_CNT_EN
  logic [15:0] r_row_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_cnt <= '0;
    end else if (w_pop && bus.wb_row_done_o) begin
      r_row_cnt <= r_row_cnt + 16'd1;
    end
  end

  assign row_cnt_o = r_row_cnt;
`else
  assign row_cnt_o = '0;
`endif
endmodule

// File: doc/handshake_pe2wb.md
# handshake_pe2wb

Receive-side handshake stage between the PE array outputs and the writeback/accumulation path. It is the consumer end of the scheduler-to-PE valid/ready protocol. It buffers PE column results in a small FIFO, drains them to writeback under a valid/ready handshake, and generates the registered `pe2sch_rdy` backpressure. That backpressure has enough slack to absorb data already in flight through the scheduler register stage and the PE pipeline.

## Interface
Parameters:
- `PE_COL_NUM`, 32: PE columns per result beat.
- `PSUM_WIDTH`, 24: partial-sum width per column.
- `FIFO_DEPTH`, 8: result entries. Must be a power of 2 and ≥ 4.
- `SLACK`, 3: free entries that must remain for `pe2sch_rdy` to stay high. Covers in-flight beats. Must be less than `FIFO_DEPTH`.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock. One clock domain for the whole block.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `pe_vld_i`, in, 1: PE result beat valid.
- `pe_row_start_i`, in, 1: beat is the first of an output row.
- `pe_row_done_i`, in, 1: beat is the last of an output row.
- `pe_col_vld_i`, in, `PE_COL_NUM`: per-column valid mask.
- `pe_psum_i`, in, `PE_COL_NUM*PSUM_WIDTH`: column results. Column 0 is in the LSBs.
- `pe2sch_rdy`, out, 1: registered backpressure to the scheduler.
- `wb_vld_o`, out, 1: head entry valid.
- `wb_rdy_i`, in, 1: writeback accepts the head entry.
- `wb_row_start_o`, out, 1: head entry tag.
- `wb_row_done_o`, out, 1: head entry tag.
- `wb_col_vld_o`, out, `PE_COL_NUM`: head entry mask.
- `wb_psum_o`, out, `PE_COL_NUM*PSUM_WIDTH`: head entry data.
- `fifo_cnt_o`, out, `$clog2(FIFO_DEPTH)+1`: current occupancy.
- `ovf_err_o`, out, 1: sticky overflow flag.
- `row_cnt_o`, out, 16: completed rows drained (see Configuration).

## Operation
- Each entry stores {row_start, row_done, col_vld, psum}. Storage is a register array with a write pointer and a read pointer, each `$clog2(FIFO_DEPTH)` bits wide and wrapping modulo `FIFO_DEPTH`. An occupancy counter tracks the fill level.
- Push occurs when `pe_vld_i` is high and the FIFO can accept: either `fifo_cnt_o < FIFO_DEPTH`, or a pop happens in the same cycle.
- Pop occurs when `wb_vld_o && wb_rdy_i`. `wb_vld_o = (fifo_cnt_o != 0)`. The `wb_*` outputs present the entry at the read pointer, first-word-fall-through from registers.
- Simultaneous push and pop: both pointers advance and the count is unchanged. This applies at full as well; no beat is lost.
- Push when full with no pop: the beat is dropped, the pointers and storage are unchanged, and `ovf_err_o` is set to 1. `ovf_err_o` clears only on reset.
- Pop when empty cannot occur, because `wb_vld_o` is 0.
- `pe2sch_rdy` next-state is `(FIFO_DEPTH - next_cnt) > SLACK`, where `next_cnt` is the occupancy after the current cycle's push/pop.
- `wb_vld_o` does not depend combinationally on `wb_rdy_i`. `wb_rdy_i` may toggle freely.
- Data on `wb_*` must hold stable while `wb_vld_o && !wb_rdy_i`.

## Timing
- Reset values: `pe2sch_rdy`=0, `wb_vld_o`=0, `wb_*` tags, mask and data all 0, `fifo_cnt_o`=0, `ovf_err_o`=0, `row_cnt_o`=0. Both pointers are 0.
- `pe2sch_rdy` rises on the first clock edge after `rst_n` deasserts.
- Push-to-output latency is 1 cycle. A beat pushed at edge N is visible on `wb_*` with `wb_vld_o`=1 after edge N. There is no combinational bypass from `pe_*` to `wb_*`.
- Pop takes effect at the clock edge. The next entry, or `wb_vld_o`=0, is visible after that same edge.
- `pe2sch_rdy` falls 1 cycle after the occupancy crosses `FIFO_DEPTH-SLACK`. Up to `SLACK` beats may still arrive after that without overflow.
- Reset mid-operation discards all entries immediately (asynchronous). No partial row state is retained.

## Configuration
- Macro `HANDSHAKE_PE2WB_ROW_CNT_EN`.
- Defined: `row_cnt_o` increments by 1 on each pop whose entry has `row_done`=1. It wraps from 0xFFFF to 0 and resets to 0.
- Undefined: the counter logic is omitted and `row_cnt_o` is tied to 0.

## Test plan
- Reset release, idle: `pe2sch_rdy`=0 during reset, then 1 one cycle after release. `wb_vld_o`=0 and `fifo_cnt_o`=0.
- Streaming with `wb_rdy_i`=1: push 16 beats with psum column 0 = 1..16. `wb_psum_o` column 0 shows 1..16 in order, each 1 cycle after its push. `fifo_cnt_o` stays ≤1 and `pe2sch_rdy` stays 1.
- Backpressure with `wb_rdy_i`=0 (defaults): push beats continuously. `pe2sch_rdy` drops 1 cycle after count reaches 5. Push 3 more in-flight beats: count reaches 8, `ovf_err_o`=0.
- Full plus a 9th push with no pop: the beat is dropped and `ovf_err_o`=1. Draining then yields exactly the first 8 values in order.
- Full with simultaneous push and pop: count stays 8, no overflow, and the new beat appears 8th in the drain order.
- With `HANDSHAKE_PE2WB_ROW_CNT_EN` defined: 3 rows of 4 beats, `row_done` on every 4th beat, random `wb_rdy_i`. `row_cnt_o`=3 after the drain. Without the macro, `row_cnt_o` stays 0.
